// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 8-bit pipelined core.
// Selects forwarded operands, computes the ALU result and registers it together
// with the memory/writeback controls that drive Data_Mem and the WB stage.
// Build option: define EXEC_MUL_EN to compile in the iterative shift-add
// multiplier and its BUSY state. Without it, alu_op 4'hB is a bubble and
// stall is tied low.
module execute_stage #(
  parameter int DW    = 8,
  parameter int RW_W  = 5,
  parameter int MUL_N = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush_ex,
  input  logic [DW-1:0]   A_in,
  input  logic [DW-1:0]   B_in,
  input  logic [DW-1:0]   imm_in,
  input  logic            imm_sel,
  input  logic [3:0]      alu_op,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [DW-1:0]   mux_ans_dm,
  input  logic [RW_W-1:0] RW_in,
  input  logic            mem_en_in,
  input  logic            mem_rw_in,
  input  logic            mem_mux_sel_in,
  output logic [DW-1:0]   ans_ex,
  output logic [DW-1:0]   B_Bypass,
  output logic [RW_W-1:0] RW_ex,
  output logic            mem_en_ex,
  output logic            mem_rw_ex,
  output logic            mem_mux_sel_ex,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_v,
  output logic            stall
);

  localparam int SH_W = $clog2(DW);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_PASS = 4'h9;
  localparam logic [3:0] OP_SLT  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] op2;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_v;
  logic [DW:0]   sum;
  logic          live;
  logic          is_nop;
  logic          is_mul;
  logic          load_alu;

  // Forwarding: select 11 falls back to the register-file value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    op_a = A_in;
    op_b = B_in;
    case (fwd_a_sel)
      2'b01:   op_a = ans_ex;
      2'b10:   op_a = mux_ans_dm;
      default: op_a = A_in;
    endcase
    case (fwd_b_sel)
      2'b01:   op_b = ans_ex;
      2'b10:   op_b = mux_ans_dm;
      default: op_b = B_in;
    endcase
  end

  assign op2    = imm_sel ? imm_in : op_b;
  assign live   = valid_in && !flush_ex;
  assign is_nop = (alu_op[3:2] == 2'b11);
  assign is_mul = (alu_op == OP_MUL);

  // Single-cycle ALU; SUB carry is the no-borrow bit of A + ~op2 + 1.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = '0;
    case (alu_op)
      OP_ADD: begin
        sum     = {1'b0, op_a} + {1'b0, op2};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (op_a[DW-1] == op2[DW-1]) && (sum[DW-1] != op_a[DW-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, op_a} + {1'b0, ~op2} + {{DW{1'b0}}, 1'b1};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (op_a[DW-1] != op2[DW-1]) && (sum[DW-1] != op_a[DW-1]);
      end
      OP_AND:  alu_res = op_a & op2;
      OP_OR:   alu_res = op_a | op2;
      OP_XOR:  alu_res = op_a ^ op2;
      OP_NOT:  alu_res = ~op_a;
      OP_SLL:  alu_res = op_a << op2[SH_W-1:0];
      OP_SRL:  alu_res = op_a >> op2[SH_W-1:0];
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> op2[SH_W-1:0]);
      OP_PASS: alu_res = op2;
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op2))};
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int CNT_W = (MUL_N > 1) ? $clog2(MUL_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_N - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   acc_nxt;
  logic [DW-1:0]   mul_b;
  logic [RW_W-1:0] mul_rw;
  logic            mul_en;
  logic            mul_wr;
  logic            mul_sel;
  logic            mul_start;
  logic            mul_done;

  // Only the low DW bits of the product are kept, so the accumulator is DW wide.
  assign acc_nxt  = acc + (mplier[cnt] ? (mcand << cnt) : '0);
  assign load_alu = live && !is_nop && !is_mul && (state == S_IDLE);

  // Multiplier FSM: next state, stall and start/done strobes.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (live && is_mul) begin
          stall     = 1'b1;
          mul_start = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Released one cycle early so upstream advances on the completing edge.
        stall = (cnt != CNT_LAST);
        if (flush_ex) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          mul_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Multiplier state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand/control capture on acceptance, then one shift-add per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mul_b   <= '0;
      mul_rw  <= '0;
      mul_en  <= 1'b0;
      mul_wr  <= 1'b0;
      mul_sel <= 1'b1;
    end else if (mul_start) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= op_a;
      mplier  <= op2;
      mul_b   <= op_b;
      mul_rw  <= RW_in;
      mul_en  <= mem_en_in;
      mul_wr  <= mem_rw_in;
      mul_sel <= mem_mux_sel_in;
    end else if (state == S_BUSY) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_nxt;
    end
  end
`else
  assign load_alu = live && !is_nop && !is_mul;
  assign stall    = 1'b0;
`endif

  // EX/MEM output register: ALU result, finished product, or a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_ex         <= '0;
      B_Bypass       <= '0;
      RW_ex          <= '0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b1;
      flag_z         <= 1'b0;
      flag_c         <= 1'b0;
      flag_v         <= 1'b0;
    end else if (load_alu) begin
      ans_ex         <= alu_res;
      B_Bypass       <= op_b;
      RW_ex          <= RW_in;
      mem_en_ex      <= mem_en_in;
      mem_rw_ex      <= mem_rw_in;
      mem_mux_sel_ex <= mem_mux_sel_in;
      flag_z         <= (alu_res == '0);
      flag_c         <= alu_c;
      flag_v         <= alu_v;
`ifdef EXEC_MUL_EN
    end else if (mul_done) begin
      ans_ex         <= acc_nxt;
      B_Bypass       <= mul_b;
      RW_ex          <= mul_rw;
      mem_en_ex      <= mul_en;
      mem_rw_ex      <= mul_wr;
      mem_mux_sel_ex <= mul_sel;
      flag_z         <= (acc_nxt == '0);
      flag_c         <= 1'b0;
      flag_v         <= 1'b0;
`endif
    end else begin
      // Bubble: kill writeback and memory access; result, store data and flags hold.
      RW_ex          <= '0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage. Expected EX/MEM register
// contents are computed from the driven stimulus and queued; each clock edge
// pops one entry and compares it with the registered outputs.
// Adapts to EXEC_MUL_EN in the same way the design does.
module tb_execute_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in, flush_ex;
  logic [7:0] A_in, B_in, imm_in, mux_ans_dm;
  logic       imm_sel;
  logic [3:0] alu_op;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [4:0] RW_in;
  logic       mem_en_in, mem_rw_in, mem_mux_sel_in;
  logic [7:0] ans_ex, B_Bypass;
  logic [4:0] RW_ex;
  logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
  logic       flag_z, flag_c, flag_v, stall;

  execute_stage dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .flush_ex       (flush_ex),
    .A_in           (A_in),
    .B_in           (B_in),
    .imm_in         (imm_in),
    .imm_sel        (imm_sel),
    .alu_op         (alu_op),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .mux_ans_dm     (mux_ans_dm),
    .RW_in          (RW_in),
    .mem_en_in      (mem_en_in),
    .mem_rw_in      (mem_rw_in),
    .mem_mux_sel_in (mem_mux_sel_in),
    .ans_ex         (ans_ex),
    .B_Bypass       (B_Bypass),
    .RW_ex          (RW_ex),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_ex (mem_mux_sel_ex),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .flag_v         (flag_v),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ans;
    logic [7:0] bb;
    logic [4:0] rw;
    logic       me, mr, ms, z, c, v;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference copy of the registers that hold across bubbles.
  logic [7:0] m_ans, m_bb;
  logic       m_z, m_c, m_v;

  task automatic model_reset();
    m_ans = 8'h00; m_bb = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
    sb_q.delete();
  endtask

  task automatic push_bubble();
    exp_t e;
    e.ans = m_ans; e.bb = m_bb; e.rw = 5'h00;
    e.me = 1'b0; e.mr = 1'b0; e.ms = 1'b1;
    e.z = m_z; e.c = m_c; e.v = m_v;
    sb_q.push_back(e);
  endtask

  task automatic push_result(input logic [7:0] r, input logic [7:0] bb, input logic [4:0] rw,
                             input logic me, input logic mr, input logic ms,
                             input logic c, input logic v);
    exp_t e;
    m_ans = r; m_bb = bb; m_z = (r == 8'h00); m_c = c; m_v = v;
    e.ans = r; e.bb = bb; e.rw = rw; e.me = me; e.mr = mr; e.ms = ms;
    e.z = m_z; e.c = c; e.v = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [7:0] fwd_val(input logic [1:0] sel, input logic [7:0] rf);
    case (sel)
      2'b01:   return m_ans;
      2'b10:   return mux_ans_dm;
      default: return rf;
    endcase
  endfunction

  // Reference ALU written with integer arithmetic on the currently driven inputs.
  task automatic predict();
    logic [7:0] a, b, o2, r;
    logic       c, v;
    int         u, sa, so, sr;
    if (!valid_in || flush_ex || alu_op >= 4'hB) begin
      push_bubble();
      return;
    end
    a  = fwd_val(fwd_a_sel, A_in);
    b  = fwd_val(fwd_b_sel, B_in);
    o2 = imm_sel ? imm_in : b;
    sa = int'($signed(a));
    so = int'($signed(o2));
    r = 8'h00; c = 1'b0; v = 1'b0; u = 0; sr = 0;
    case (alu_op)
      4'h0: begin u = int'(a) + int'(o2); r = u[7:0]; c = (u > 255);
                  sr = sa + so; v = (sr > 127) || (sr < -128); end
      4'h1: begin u = int'(a) - int'(o2); r = u[7:0]; c = (a >= o2);
                  sr = sa - so; v = (sr > 127) || (sr < -128); end
      4'h2: r = a & o2;
      4'h3: r = a | o2;
      4'h4: r = a ^ o2;
      4'h5: r = ~a;
      4'h6: r = a << o2[2:0];
      4'h7: r = a >> o2[2:0];
      4'h8: begin
        r = a;
        for (int k = 0; k < int'(o2[2:0]); k++) r = {r[7], r[7:1]};
      end
      4'h9: r = o2;
      default: r = (sa < so) ? 8'h01 : 8'h00;
    endcase
    push_result(r, b, RW_in, mem_en_in, mem_rw_in, mem_mux_sel_in, c, v);
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; flush_ex = 1'b0; A_in = 8'h00; B_in = 8'h00; imm_in = 8'h00;
    imm_sel = 1'b0; alu_op = 4'h0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    mux_ans_dm = 8'h00; RW_in = 5'h00; mem_en_in = 1'b0; mem_rw_in = 1'b0;
    mem_mux_sel_in = 1'b1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] imm, input logic isel,
                          input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] dm,
                          input logic [4:0] rw, input logic me, input logic mr, input logic ms);
    valid_in = 1'b1; flush_ex = 1'b0; alu_op = op; A_in = a; B_in = b; imm_in = imm;
    imm_sel = isel; fwd_a_sel = fa; fwd_b_sel = fb; mux_ans_dm = dm; RW_in = rw;
    mem_en_in = me; mem_rw_in = mr; mem_mux_sel_in = ms;
  endtask

  // Advance one edge, then compare the registered outputs with the next queued entry.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
      return;
    end
    e = sb_q.pop_front();
    if ({ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, flag_z, flag_c, flag_v} !==
        {e.ans, e.bb, e.rw, e.me, e.mr, e.ms, e.z, e.c, e.v}) begin
      bad++;
      $display("FAIL %s: got ans=%h bb=%h rw=%h en=%b wr=%b sel=%b zcv=%b%b%b, want ans=%h bb=%h rw=%h en=%b wr=%b sel=%b zcv=%b%b%b",
               tag, ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, flag_z, flag_c, flag_v,
               e.ans, e.bb, e.rw, e.me, e.mr, e.ms, e.z, e.c, e.v);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #200;
    reset = 1'b1;
    #1;
    total++;
    if ({ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, flag_z, flag_c, flag_v, stall} !==
        {8'h00, 8'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got ans=%h bb=%h rw=%h en=%b wr=%b sel=%b zcv=%b%b%b stall=%b, want all 0 except sel=1",
               ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, flag_z, flag_c, flag_v, stall);
    end
    push_bubble();
    step("reset_idle");
  endtask

  task automatic test_add_overflow();
    drive_op(4'h0, 8'h7F, 8'h00, 8'h01, 1'b1, 2'b00, 2'b00, 8'h00, 5'h03, 1'b0, 1'b0, 1'b1);
    predict();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL add_stall: got %b want 0", stall); end
    step("add_overflow");
    total++;
    if ({ans_ex, flag_v, flag_c, flag_z, RW_ex} !== {8'h80, 1'b1, 1'b0, 1'b0, 5'h03}) begin
      bad++;
      $display("FAIL add_overflow_direct: got ans=%h v=%b c=%b z=%b rw=%h want 80 1 0 0 03",
               ans_ex, flag_v, flag_c, flag_z, RW_ex);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    drive_op(4'h0, 8'h7F, 8'h00, 8'h01, 1'b1, 2'b00, 2'b00, 8'h00, 5'h04, 1'b0, 1'b0, 1'b1);
    predict();
    step("b2b_add");
    drive_op(4'h1, 8'h11, 8'h80, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 5'h05, 1'b0, 1'b0, 1'b1);
    predict();
    step("b2b_sub");
    total++;
    if ({ans_ex, flag_z, flag_c} !== {8'h00, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL b2b_sub_direct: got ans=%h z=%b c=%b want 00 1 1", ans_ex, flag_z, flag_c);
    end
    // Shift-by-zero and signed boundaries.
    drive_op(4'h6, 8'hA5, 8'h00, 8'h08, 1'b1, 2'b00, 2'b00, 8'h00, 5'h06, 1'b0, 1'b0, 1'b1);
    predict(); step("sll_by_0");
    drive_op(4'h7, 8'hA5, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00, 5'h06, 1'b0, 1'b0, 1'b1);
    predict(); step("srl_by_0");
    drive_op(4'h8, 8'h90, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00, 5'h06, 1'b0, 1'b0, 1'b1);
    predict(); step("sra_by_0");
    drive_op(4'h8, 8'h90, 8'h00, 8'h03, 1'b1, 2'b00, 2'b00, 8'h00, 5'h06, 1'b0, 1'b0, 1'b1);
    predict(); step("sra_neg");
    drive_op(4'hA, 8'h80, 8'h01, 8'h00, 1'b0, 2'b00, 2'b11, 8'h00, 5'h07, 1'b0, 1'b0, 1'b1);
    predict(); step("slt_signed");
    drive_op(4'h1, 8'h00, 8'h01, 8'h00, 1'b0, 2'b11, 2'b00, 8'h00, 5'h07, 1'b0, 1'b0, 1'b1);
    predict(); step("sub_borrow");
    drive_op(4'h1, 8'h80, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 5'h07, 1'b0, 1'b0, 1'b1);
    predict(); step("sub_overflow");
    for (int i = 0; i < 33; i++) begin
      drive_op(ops[i % 11], 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
               2'($urandom), 2'($urandom), 8'($urandom), 5'($urandom), 1'b0, 1'b0, 1'($urandom));
      predict();
      step("random_op");
    end
  endtask

  task automatic test_store();
    drive_op(4'h0, 8'h20, 8'h99, 8'h04, 1'b1, 2'b00, 2'b10, 8'h50, 5'h00, 1'b1, 1'b1, 1'b0);
    predict();
    step("store");
    total++;
    if ({B_Bypass, mem_en_ex, mem_rw_ex, ans_ex} !== {8'h50, 1'b1, 1'b1, 8'h24}) begin
      bad++;
      $display("FAIL store_direct: got bb=%h en=%b wr=%b ans=%h want 50 1 1 24",
               B_Bypass, mem_en_ex, mem_rw_ex, ans_ex);
    end
  endtask

  task automatic test_bubbles();
    drive_op(4'h9, 8'h00, 8'h00, 8'h5A, 1'b1, 2'b00, 2'b00, 8'h00, 5'h01, 1'b0, 1'b0, 1'b1);
    predict(); step("set_hold");
    drive_op(4'h0, 8'h01, 8'h02, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 5'h09, 1'b1, 1'b1, 1'b0);
    valid_in = 1'b0;
    predict(); step("bubble_invalid");
    drive_op(4'h0, 8'h01, 8'h02, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 5'h09, 1'b1, 1'b1, 1'b0);
    flush_ex = 1'b1;
    predict(); step("bubble_flush");
    for (int op = 12; op < 16; op++) begin
      drive_op(4'(op), 8'h33, 8'h44, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 5'h0A, 1'b1, 1'b0, 1'b0);
      predict(); step("bubble_nop");
    end
  endtask

  task automatic test_mul();
    drive_op(4'h9, 8'h00, 8'h00, 8'h3C, 1'b1, 2'b00, 2'b00, 8'h00, 5'h01, 1'b0, 1'b0, 1'b1);
    predict(); step("mul_pre");
    drive_op(4'hB, 8'h00, 8'h0B, 8'h00, 1'b0, 2'b10, 2'b00, 8'h0D, 5'h07, 1'b0, 1'b0, 1'b1);
`ifdef EXEC_MUL_EN
    for (int i = 0; i < 8; i++) begin
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL mul_stall_high: cycle %0d got %b want 1", i, stall); end
      push_bubble();
      step("mul_busy_bubble");
      if (i == 0) begin mux_ans_dm = 8'hFF; A_in = 8'h55; end
    end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL mul_stall_release: got %b want 0", stall); end
    push_result(8'h8F, 8'h0B, 5'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mul_product");
`else
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL mul_disabled_stall: got %b want 0", stall); end
    predict();
    step("mul_disabled_bubble");
`endif
    idle_inputs();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL mul_after_stall: got %b want 0", stall); end
    push_bubble();
    step("mul_after");
  endtask

  task automatic test_mul_abort();
    drive_op(4'h9, 8'h00, 8'h00, 8'h3C, 1'b1, 2'b00, 2'b00, 8'h00, 5'h01, 1'b0, 1'b0, 1'b1);
    predict(); step("abort_pre");
`ifdef EXEC_MUL_EN
    drive_op(4'hB, 8'h0D, 8'h0B, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 5'h09, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin push_bubble(); step("abort_flush_busy"); end
    flush_ex = 1'b1;
    valid_in = 1'b0;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL abort_flush_stall: got %b want 1", stall); end
    push_bubble(); step("abort_flush_edge");
    idle_inputs();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL abort_flush_idle: got stall %b want 0", stall); end
    for (int i = 0; i < 12; i++) begin push_bubble(); step("abort_flush_no_product"); end
`endif
    drive_op(4'hB, 8'h0D, 8'h0B, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 5'h09, 1'b0, 1'b0, 1'b1);
`ifdef EXEC_MUL_EN
    for (int i = 0; i < 3; i++) begin push_bubble(); step("abort_reset_busy"); end
`else
    predict(); step("abort_reset_bubble");
`endif
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, flag_z, flag_c, flag_v, stall} !==
        {8'h00, 8'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_reset_values: got ans=%h bb=%h rw=%h en=%b wr=%b sel=%b zcv=%b%b%b stall=%b",
               ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, flag_z, flag_c, flag_v, stall);
    end
    model_reset();
    #10;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 12; i++) begin push_bubble(); step("abort_reset_no_product"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_store();
    test_bubbles();
    test_mul();
    test_mul_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
